gpr_file: RTL

Parametrised general-purpose register file for the picoMIPS datapath. It generalises the fixed 4-entry file to 2^AW entries of n bits, with two combinational read ports and one synchronous write port. Register 0 always reads as zero. Per-port zero-force inputs are retained. New features: an optional write-to-read bypass and a sequential clear sweep that zeroes every register after reset or on request, with a `ready` flag that gates all use of the file.

---
 rtl/gpr_file_if.sv | 28 ++
 rtl/gpr_file.sv | 126 ++++++++++++
 2 files changed

// File: rtl/gpr_file_if.sv
// Bus bundle for gpr_file: one write port, two read ports with zero-force,
// the clear request and the ready flag. clk and reset stay outside the bundle.
interface gpr_file_if #(
  parameter int n  = 8,
  parameter int AW = 3
);
  logic          we;
  logic [AW-1:0] waddr;
  logic [n-1:0]  wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic          zsel1;
  logic          zsel2;
  logic          clr;
  logic [n-1:0]  rdata1;
  logic [n-1:0]  rdata2;
  logic          ready;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, zsel1, zsel2, clr,
    input  rdata1, rdata2, ready
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, zsel1, zsel2, clr,
    output rdata1, rdata2, ready
  );
endinterface

// File: rtl/gpr_file.sv
// Parametrised picoMIPS register file: 2^AW entries of n bits, register 0
// hard-wired to zero, two combinational read ports, one synchronous write
// port, optional write-to-read forwarding and a sequential clear sweep that
// must finish (ready=1) before the file can be read or written.
module gpr_file #(
  parameter int n      = 8,
  parameter int AW     = 3,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        reset,
  gpr_file_if.slave   bus
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] ONE   = AW'(1);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_ready;
  logic [n-1:0]  r_gpr [DEPTH-1:1];

  logic          w_wrEn;
  logic [AW-1:0] w_wrAddr;
  logic [n-1:0]  w_wrData;
  logic          w_fwd1;
  logic          w_fwd2;
  logic [n-1:0]  w_rd1;
  logic [n-1:0]  w_rd2;

  // Sweep/run controller: reset and clr both restart the sweep at register 1;
  // ready is registered and rises on the edge that clears the last register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= ONE;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_cnt == LAST) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        RUN: begin
          if (bus.clr) begin
            r_state <= CLEAR;
            r_cnt   <= ONE;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_cnt   <= ONE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Select the single storage write of this edge: the sweep zeroes gpr[cnt],
  // otherwise a user write lands unless clr wins or it targets register 0.
  always_comb begin
    w_wrEn   = 1'b0;
    w_wrAddr = r_cnt;
    w_wrData = '0;
    if (!reset) begin
      if (r_state == CLEAR) begin
        w_wrEn = 1'b1;
      end else if (!bus.clr && bus.we && (bus.waddr != '0)) begin
        w_wrEn   = 1'b1;
        w_wrAddr = bus.waddr;
        w_wrData = bus.wdata;
      end
    end
  end

  // Storage array; there is no entry for register 0 and no reset on data.
  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      r_gpr[w_wrAddr] <= w_wrData;
    end
  end

  // Forwarding hits: a write that will actually commit this edge to the
  // address being read (only meaningful while ready, which implies RUN).
  always_comb begin
    w_fwd1 = (BYPASS != 0) && bus.we && !bus.clr && (bus.waddr == bus.raddr1);
    w_fwd2 = (BYPASS != 0) && bus.we && !bus.clr && (bus.waddr == bus.raddr2);
  end

  // Read port 1: zero-force, not-ready and register 0 all read as zero.
  always_comb begin
    w_rd1 = '0;
    if (!bus.zsel1 && r_ready && (bus.raddr1 != '0)) begin
      if (w_fwd1) begin
        w_rd1 = bus.wdata;
      end else begin
        w_rd1 = r_gpr[bus.raddr1];
      end
    end
  end

  // Read port 2: same priority as port 1, fully independent of it.
  always_comb begin
    w_rd2 = '0;
    if (!bus.zsel2 && r_ready && (bus.raddr2 != '0)) begin
      if (w_fwd2) begin
        w_rd2 = bus.wdata;
      end else begin
        w_rd2 = r_gpr[bus.raddr2];
      end
    end
  end

  assign bus.rdata1 = w_rd1;
  assign bus.rdata2 = w_rd2;
  assign bus.ready  = r_ready;

endmodule
